// File: rtl/ahb2_arbiter.sv
// Round-robin AHB2 bus arbiter: one-hot grant, address/data-phase owner
// indices, and fixed-length burst protection via a remaining-beat counter.
module ahb2_arbiter #(
  parameter int unsigned N_MST       = 4,
  parameter int unsigned DEFAULT_MST = 0,
  parameter int unsigned MW          = $clog2(N_MST)
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic [N_MST-1:0]  hbusreq,
  output logic [N_MST-1:0]  hgrant,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic              hready,
  output logic [MW-1:0]     hmaster,
  output logic [MW-1:0]     hmaster_data
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  localparam logic [N_MST-1:0] DEF_GRANT = N_MST'(1) << DEFAULT_MST;
  localparam logic [MW-1:0]    DEF_IDX   = MW'(DEFAULT_MST);

  htrans_t          trans;
  logic [3:0]       cnt;
  logic [3:0]       bl;
  logic             open;
  logic [MW-1:0]    nxt_idx;
  logic [MW-1:0]    cand;
  logic             found;
  logic [MW-1:0]    grant_idx;

  assign trans = htrans_t'(htrans);

  always_comb begin
    bl = '0;
    case (trans)
      TR_NONSEQ: begin
        case (hburst)
          3'd2, 3'd3: bl = 4'd3;
          3'd4, 3'd5: bl = 4'd7;
          3'd6, 3'd7: bl = 4'd15;
          default:    bl = '0;
        endcase
      end
      TR_SEQ:  bl = (cnt == '0) ? '0 : cnt - 4'd1;
      TR_BUSY: bl = cnt;
      default: bl = '0;
    endcase
  end

  assign open = hready && (bl <= 4'd1);

  // Search starts after the address-phase owner, so a freshly moved grant
  // stays put until hmaster catches up with it.
  always_comb begin
    nxt_idx = DEF_IDX;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_MST; i++) begin
      cand = MW'((32'(hmaster) + i) % N_MST);
      if (!found && hbusreq[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (hgrant[i]) grant_idx = MW'(i);
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hgrant       <= DEF_GRANT;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      cnt          <= '0;
    end else if (hready) begin
      cnt          <= bl;
      hmaster      <= grant_idx;
      hmaster_data <= hmaster;
      if (open) hgrant <= N_MST'(1) << nxt_idx;
    end
  end

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Table-driven bench for ahb2_arbiter with a queue-based scoreboard.
module tb_ahb2_arbiter;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SEQ = 2'd3;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hbusreq;
  logic [3:0] hgrant;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;

  ahb2_arbiter #(.N_MST(4), .DEFAULT_MST(0)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hbusreq(hbusreq), .hgrant(hgrant),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hmaster(hmaster), .hmaster_data(hmaster_data)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(string name, logic rst, logic [3:0] req, logic [1:0] trans,
                     logic [2:0] burst, logic ready, logic [3:0] g, logic [1:0] m,
                     logic [1:0] md);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.trans = trans; v.burst = burst;
    v.ready = ready; v.g = g; v.m = m; v.md = md;
    vecs.push_back(v);
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_out(exp_t e);
    check({e.name, " hgrant"}, int'(hgrant), int'(e.g));
    check({e.name, " hmaster"}, int'(hmaster), int'(e.m));
    check({e.name, " hmaster_data"}, int'(hmaster_data), int'(e.md));
    check({e.name, " onehot"}, $countones(hgrant), 1);
  endtask

  task automatic drive(logic [3:0] req, logic [1:0] trans, logic [2:0] burst, logic ready);
    hbusreq = req; htrans = trans; hburst = burst; hready = ready;
  endtask

  // Entered and left at a falling edge.
  task automatic step(string name, logic [3:0] req, logic [1:0] trans, logic [2:0] burst,
                      logic ready, logic [3:0] g, logic [1:0] m, logic [1:0] md);
    exp_t e;
    drive(req, trans, burst, ready);
    e.name = name; e.g = g; e.m = m; e.md = md;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", name);
    end else begin
      compare_out(sb.pop_front());
    end
    @(negedge hclk);
  endtask

  task automatic apply_reset();
    exp_t e;
    hreset_n = 1'b0;
    drive(4'b0000, IDLE, 3'd0, 1'b1);
    #1;
    e.name = "reset"; e.g = 4'b0001; e.m = 2'd0; e.md = 2'd0;
    compare_out(e);
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  initial begin
    exp_t e;

    // Test 1: idle after reset
    for (int i = 0; i < 10; i++) add("t1_idle", 1'b0, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0);

    // Test 2: round robin, all requesting SINGLEs
    add("t2_rr0", 1'b1, 4'b1111, NS, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0);
    add("t2_rr1", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0);
    add("t2_rr2", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b0100, 2'd1, 2'd1);
    add("t2_rr3", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd1);
    add("t2_rr4", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b1000, 2'd2, 2'd2);
    add("t2_rr5", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b1000, 2'd3, 2'd2);
    add("t2_rr6", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b0001, 2'd3, 2'd3);
    add("t2_rr7", 1'b0, 4'b1111, NS, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd3);

    // Test 3: INCR8 from M1 with M2 waiting
    add("t3_own0", 1'b1, 4'b0010, IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0);
    add("t3_own1", 1'b0, 4'b0010, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0);
    add("t3_b1",   1'b0, 4'b0110, NS,   3'd5, 1'b1, 4'b0010, 2'd1, 2'd1);
    for (int i = 2; i <= 6; i++) add($sformatf("t3_b%0d", i), 1'b0, 4'b0110, SEQ, 3'd5, 1'b1, 4'b0010, 2'd1, 2'd1);
    add("t3_b7",   1'b0, 4'b0110, SEQ,  3'd5, 1'b1, 4'b0100, 2'd1, 2'd1);
    add("t3_b8",   1'b0, 4'b0110, SEQ,  3'd5, 1'b1, 4'b0100, 2'd2, 2'd1);
    add("t3_m2",   1'b0, 4'b0100, NS,   3'd0, 1'b1, 4'b0100, 2'd2, 2'd2);

    // Test 4: WRAP4 with wait states and a BUSY beat
    add("t4_own0", 1'b1, 4'b0010, IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0);
    add("t4_own1", 1'b0, 4'b0010, IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0);
    add("t4_b1",   1'b0, 4'b0110, NS,   3'd2, 1'b1, 4'b0010, 2'd1, 2'd1);
    for (int i = 0; i < 3; i++) add("t4_wait", 1'b0, 4'b0110, SEQ, 3'd2, 1'b0, 4'b0010, 2'd1, 2'd1);
    add("t4_b2",   1'b0, 4'b0110, SEQ,  3'd2, 1'b1, 4'b0010, 2'd1, 2'd1);
    add("t4_busy", 1'b0, 4'b0110, BUSY, 3'd2, 1'b1, 4'b0010, 2'd1, 2'd1);
    add("t4_w3",   1'b0, 4'b0110, SEQ,  3'd2, 1'b0, 4'b0010, 2'd1, 2'd1);
    add("t4_b3",   1'b0, 4'b0110, SEQ,  3'd2, 1'b1, 4'b0100, 2'd1, 2'd1);
    add("t4_b4",   1'b0, 4'b0110, SEQ,  3'd2, 1'b1, 4'b0100, 2'd2, 2'd1);
    add("t4_m2",   1'b0, 4'b0100, IDLE, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd2);

    // Test 5: M3 drops its request, fall back to default
    add("t5_own0", 1'b1, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd0, 2'd0);
    add("t5_own1", 1'b0, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd3, 2'd0);
    add("t5_own2", 1'b0, 4'b1000, IDLE, 3'd0, 1'b1, 4'b1000, 2'd3, 2'd3);
    add("t5_drop", 1'b0, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd3, 2'd3);
    add("t5_wait", 1'b0, 4'b0000, IDLE, 3'd0, 1'b0, 4'b0001, 2'd3, 2'd3);
    add("t5_def",  1'b0, 4'b0000, IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd3);

    hreset_n = 1'b0;
    drive(4'b0000, IDLE, 3'd0, 1'b1);
    @(negedge hclk);
    #1;
    e.name = "t1_reset"; e.g = 4'b0001; e.m = 2'd0; e.md = 2'd0;
    compare_out(e);
    @(negedge hclk);
    hreset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      step(vecs[i].name, vecs[i].req, vecs[i].trans, vecs[i].burst, vecs[i].ready,
           vecs[i].g, vecs[i].m, vecs[i].md);
    end

    // Test 6: asynchronous reset in the middle of an INCR16 from M2
    apply_reset();
    step("t6_own0", 4'b0100, IDLE, 3'd0, 1'b1, 4'b0100, 2'd0, 2'd0);
    step("t6_own1", 4'b0100, IDLE, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd0);
    step("t6_b1",   4'b0101, NS,   3'd7, 1'b1, 4'b0100, 2'd2, 2'd2);
    for (int i = 2; i <= 5; i++) step($sformatf("t6_b%0d", i), 4'b0101, SEQ, 3'd7, 1'b1, 4'b0100, 2'd2, 2'd2);
    #2;
    hreset_n = 1'b0;
    #1;
    e.name = "t6_async"; e.g = 4'b0001; e.m = 2'd0; e.md = 2'd0;
    compare_out(e);
    @(negedge hclk);
    hreset_n = 1'b1;
    // cnt must be clear: BUSY carries cnt straight into bl
    step("t6_cnt",  4'b0010, BUSY, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0);
    step("t6_m0a",  4'b0001, NS,   3'd0, 1'b1, 4'b0001, 2'd1, 2'd0);
    step("t6_m0b",  4'b0001, NS,   3'd0, 1'b1, 4'b0001, 2'd0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
